// File: rtl/rtc_pkg.sv
// rtc_pkg: shared constants, enums and helpers for the RTC timebase (optional BCD load via RTC_BCD_LOAD_EN)
package rtc_pkg;
  localparam logic [31:0] MAC_UNIX_EPOCH_OFFSET = 32'h7C25B080;
  typedef enum logic [1:0] {LANE_B0, LANE_B1, LANE_B2, LANE_B3} lane_t;
  typedef enum logic {WAIT_TS, RUN} state_t;
  localparam int BCD_SEC = 0;
  localparam int BCD_MIN = 8;
  localparam int BCD_HOUR = 16;
  localparam int BCD_DATE = 24;
  localparam int BCD_MONTH = 32;
  localparam int BCD_YEAR = 40;
  localparam int BCD_DOW = 48;
  localparam int BCD_TOGGLE = 64;
  function automatic logic [6:0] bcd2bin(input logic [7:0] b);
    return 7'(b[7:4]) * 7'd10 + 7'(b[3:0]);
  endfunction
  function automatic logic [8:0] cum_days(input logic [3:0] m);
    case (m)
      4'd2: return 9'd31;
      4'd3: return 9'd59;
      4'd4: return 9'd90;
      4'd5: return 9'd120;
      4'd6: return 9'd151;
      4'd7: return 9'd181;
      4'd8: return 9'd212;
      4'd9: return 9'd243;
      4'd10: return 9'd273;
      4'd11: return 9'd304;
      4'd12: return 9'd334;
      default: return 9'd0;
    endcase
  endfunction
endpackage

// File: rtl/rtc_bcd_to_secs.sv
// rtc_bcd_to_secs: BCD calendar to Mac-epoch seconds, sequential shift-add (used with RTC_BCD_LOAD_EN)
module rtc_bcd_to_secs import rtc_pkg::*; (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [47:0] rtc,
  output logic        busy,
  output logic        done,
  output logic [31:0] secs_out
);
  logic [6:0] sec, min, hour, date, month, yy;
  logic [7:0] yo;
  logic [16:0] days, d_q;
  logic [31:0] hms, m_q;
  logic [4:0] cnt;
  // Two-digit year windowed: 04..99 -> 1904..1999, 00..03 -> 2000..2003
  always_comb begin
    sec = bcd2bin(rtc[BCD_SEC +: 8]);
    min = bcd2bin(rtc[BCD_MIN +: 8]);
    hour = bcd2bin(rtc[BCD_HOUR +: 8]);
    date = bcd2bin(rtc[BCD_DATE +: 8]);
    month = bcd2bin(rtc[BCD_MONTH +: 8]);
    yy = bcd2bin(rtc[BCD_YEAR +: 8]);
    yo = yy < 7'd4 ? 8'(yy + 7'd96) : 8'(yy - 7'd4);
    days = 17'(yo) * 17'd365 + 17'((yo + 8'd3) >> 2) + 17'(cum_days(month[3:0]))
         + {16'd0, yo[1:0] == 2'b00 && month > 7'd2} + 17'(date) - 17'd1;
    hms = 32'(hour) * 32'd3600 + 32'(min) * 32'd60 + 32'(sec);
  end
  always_ff @(posedge clk) begin
    if (reset || abort) begin
      busy <= 1'b0;
      done <= 1'b0;
      cnt <= '0;
      d_q <= '0;
      m_q <= '0;
      secs_out <= '0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        busy <= 1'b1;
        cnt <= '0;
        d_q <= days;
        m_q <= 32'd86400;
        secs_out <= hms;
      end else if (busy) begin
        secs_out <= secs_out + (d_q[0] ? m_q : 32'd0);
        d_q <= d_q >> 1;
        m_q <= m_q << 1;
        cnt <= cnt + 5'd1;
        busy <= cnt != 5'd16;
        done <= cnt == 5'd16;
      end
    end
  end
endmodule

// File: rtl/rtc_timebase.sv
// rtc_timebase: Mac-epoch seconds counter, 1 Hz onesec and byte-lane writes (optional BCD load via RTC_BCD_LOAD_EN)
module rtc_timebase import rtc_pkg::*; #(
  parameter int          CLK_HZ       = 32000000,
  parameter logic [31:0] EPOCH_OFFSET = MAC_UNIX_EPOCH_OFFSET
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [32:0] timestamp,
  input  logic        wr_en,
  input  logic [1:0]  wr_lane,
  input  logic [7:0]  wr_data,
  input  logic        wp,
`ifdef RTC_BCD_LOAD_EN
  input  logic [64:0] rtc,
`endif
  output logic [31:0] secs,
  output logic        secs_valid,
  output logic        tick,
  output logic        onesec
);
  localparam int PW = $clog2(CLK_HZ);
  localparam logic [PW-1:0] TC = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] HALF = PW'(CLK_HZ / 2);
  state_t state, state_n;
  logic [PW-1:0] presc, presc_n;
  logic [31:0] secs_n, secs_inc, secs_wr, load_val;
  logic ts_toggle_d, ts_req, wr_ok, wr0, term, load;
`ifdef RTC_BCD_LOAD_EN
  logic rtc_tog_d, bcd_start, bcd_busy, bcd_done;
  logic [31:0] bcd_secs;
  assign bcd_start = rtc[BCD_TOGGLE] != rtc_tog_d && !ts_req && !bcd_busy;
  rtc_bcd_to_secs u_bcd (
    .clk(clk), .reset(reset), .start(bcd_start), .abort(ts_req), .rtc(rtc[47:0]),
    .busy(bcd_busy), .done(bcd_done), .secs_out(bcd_secs)
  );
  always_ff @(posedge clk) rtc_tog_d <= rtc[BCD_TOGGLE];
`endif
  // Lane-0 writes restart the second, so they drop the pending increment
  always_comb begin
    ts_req = timestamp[32] != ts_toggle_d;
`ifdef RTC_BCD_LOAD_EN
    load = ts_req || bcd_done;
    load_val = ts_req ? timestamp[31:0] + EPOCH_OFFSET : bcd_secs;
`else
    load = ts_req;
    load_val = timestamp[31:0] + EPOCH_OFFSET;
`endif
    wr_ok = wr_en && !wp;
    wr0 = wr_ok && lane_t'(wr_lane) == LANE_B0;
    term = state == RUN && presc == TC;
    secs_inc = term ? secs + 32'd1 : secs;
    secs_wr = wr0 ? secs : secs_inc;
    secs_wr[{wr_lane, 3'b000} +: 8] = wr_data;
    secs_n = load ? load_val : wr_ok ? secs_wr : secs_inc;
    presc_n = (load || wr0 || state != RUN || term) ? '0 : PW'(presc + 1'b1);
    state_n = (load || wr_ok) ? RUN : state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= WAIT_TS;
      presc <= '0;
      secs <= '0;
      secs_valid <= 1'b0;
      tick <= 1'b0;
      onesec <= 1'b0;
      ts_toggle_d <= timestamp[32];
    end else begin
      state <= state_n;
      presc <= presc_n;
      secs <= secs_n;
      secs_valid <= secs_valid || load || wr_ok;
      tick <= term && !load && !wr0;
      onesec <= state_n == RUN && presc_n < HALF;
      ts_toggle_d <= timestamp[32];
    end
  end
endmodule

// File: tb/tb_rtc_timebase.sv
// tb_rtc_timebase: directed self-checking bench for rtc_timebase with CLK_HZ=10 (BCD steps under RTC_BCD_LOAD_EN)
module tb_rtc_timebase;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [32:0] timestamp = '0;
  logic wr_en = 1'b0;
  logic [1:0] wr_lane = 2'd0;
  logic [7:0] wr_data = 8'd0;
  logic wp = 1'b0;
  logic [31:0] secs;
  logic secs_valid, tick, onesec;
  int n_vec = 0;
  int n_bad = 0;
`ifdef RTC_BCD_LOAD_EN
  logic [64:0] rtc = '0;
`endif
  rtc_timebase #(.CLK_HZ(10)) dut (
    .clk(clk), .reset(reset), .timestamp(timestamp), .wr_en(wr_en), .wr_lane(wr_lane),
    .wr_data(wr_data), .wp(wp),
`ifdef RTC_BCD_LOAD_EN
    .rtc(rtc),
`endif
    .secs(secs), .secs_valid(secs_valid), .tick(tick), .onesec(onesec)
  );
  always #5 clk = ~clk;
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [1:0] lane, input logic [7:0] data, input logic prot);
    wr_en = 1'b1;
    wr_lane = lane;
    wr_data = data;
    wp = prot;
    cyc();
    wr_en = 1'b0;
    wp = 1'b0;
  endtask
  initial begin
    cyc(2);
    chk("rst_secs", secs, 32'd0);
    chk("rst_valid", 32'(secs_valid), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_onesec", 32'(onesec), 32'd0);
    reset = 1'b0;
    cyc(3);
    chk("wait_frozen", secs, 32'd0);
    chk("wait_onesec", 32'(onesec), 32'd0);
    timestamp = {1'b1, 32'd0};
    cyc();
    chk("load0_secs", secs, 32'h7C25B080);
    chk("load0_valid", 32'(secs_valid), 32'd1);
    chk("load0_onesec", 32'(onesec), 32'd1);
    chk("load0_tick", 32'(tick), 32'd0);
    for (int k = 1; k < 10; k++) begin
      cyc();
      chk($sformatf("onesec_c%0d", k), 32'(onesec), 32'(k < 5));
      chk($sformatf("notick_c%0d", k), 32'(tick), 32'd0);
    end
    cyc();
    chk("inc_secs", secs, 32'h7C25B081);
    chk("inc_tick", 32'(tick), 32'd1);
    chk("inc_onesec", 32'(onesec), 32'd1);
    cyc();
    chk("tick_pulse", 32'(tick), 32'd0);
    timestamp = {1'b0, 32'h83DA4F7F};
    cyc();
    chk("loadmax_secs", secs, 32'hFFFFFFFF);
    cyc(10);
    chk("wrap_secs", secs, 32'h00000000);
    chk("wrap_tick", 32'(tick), 32'd1);
    wr(2'd2, 8'h55, 1'b1);
    chk("wp_ignored", secs, 32'h00000000);
    wr(2'd2, 8'h55, 1'b0);
    chk("wr_lane2", secs, 32'h00550000);
    timestamp = {1'b1, 32'h83DA507F};
    cyc();
    chk("loadff_secs", secs, 32'h000000FF);
    cyc(9);
    wr(2'd1, 8'hAA, 1'b0);
    chk("wr1_tc_secs", secs, 32'h0000AA00);
    chk("wr1_tc_tick", 32'(tick), 32'd1);
    cyc(9);
    wr(2'd0, 8'h12, 1'b0);
    chk("wr0_tc_secs", secs, 32'h0000AA12);
    chk("wr0_tc_tick", 32'(tick), 32'd0);
    cyc(3);
    wr(2'd0, 8'h20, 1'b0);
    chk("wr0_mid_secs", secs, 32'h0000AA20);
    chk("wr0_mid_onesec", 32'(onesec), 32'd1);
    cyc(9);
    chk("wr0_clr_hold", secs, 32'h0000AA20);
    chk("wr0_clr_notick", 32'(tick), 32'd0);
    cyc();
    chk("wr0_clr_secs", secs, 32'h0000AA21);
    chk("wr0_clr_tick", 32'(tick), 32'd1);
    cyc(9);
    timestamp = {1'b0, 32'h12345678};
    wr(2'd3, 8'hEE, 1'b0);
    chk("prio_secs", secs, 32'h8E5A06F8);
    chk("prio_tick", 32'(tick), 32'd0);
    chk("prio_onesec", 32'(onesec), 32'd1);
    cyc(3);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("rst2_secs", secs, 32'd0);
    chk("rst2_valid", 32'(secs_valid), 32'd0);
    chk("rst2_onesec", 32'(onesec), 32'd0);
    chk("rst2_tick", 32'(tick), 32'd0);
    cyc(12);
    chk("rst2_frozen", secs, 32'd0);
    chk("rst2_idle", 32'(onesec), 32'd0);
    wr(2'd1, 8'h01, 1'b0);
    chk("wrwait_secs", secs, 32'h00000100);
    chk("wrwait_valid", 32'(secs_valid), 32'd1);
    chk("wrwait_onesec", 32'(onesec), 32'd1);
    cyc(10);
    chk("wrwait_inc", secs, 32'h00000101);
    chk("wrwait_tick", 32'(tick), 32'd1);
`ifdef RTC_BCD_LOAD_EN
    for (int v = 0; v < 2; v++) begin
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      rtc = {~rtc[64], 8'h00, 8'h05, (v == 0) ? 8'h04 : 8'h70, 8'h01, 8'h01, 24'h000000};
      for (int i = 0; i < 60 && !secs_valid; i++) cyc();
      chk($sformatf("bcd%0d_valid", v), 32'(secs_valid), 32'd1);
      chk($sformatf("bcd%0d_secs", v), secs, (v == 0) ? 32'd0 : 32'h7C25B080);
    end
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
